// File: rtl/fifo_rd_pkg.sv
// Shared constants, state encoding and buffer pointer helper for the FIFO read scheduler.
package fifo_rd_pkg;
  localparam int DW        = 16;
  localparam int LENW      = 10;
  localparam int BUF_DEPTH = 3;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  // Circular pointer over BUF_DEPTH entries.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction
endpackage

// File: rtl/fifo_rd_buf.sv
// 3-entry circular output buffer; optional per-entry last bit when FIFO_RD_LAST_EN is defined.
module fifo_rd_buf
  import fifo_rd_pkg::*;
#(
  parameter int DW = fifo_rd_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_data,
`ifdef FIFO_RD_LAST_EN
  input  logic          i_last,
  output logic          o_last,
`endif
  output logic [1:0]    o_occ,
  output logic [DW-1:0] o_data
);
  logic [DW-1:0] r_mem [BUF_DEPTH];
  logic [1:0]    r_wr, r_rd, r_occ;
`ifdef FIFO_RD_LAST_EN
  logic          r_lst [BUF_DEPTH];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_occ <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_mem[i] <= '0;
`ifdef FIFO_RD_LAST_EN
        r_lst[i] <= 1'b0;
`endif
      end
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_data;
`ifdef FIFO_RD_LAST_EN
        r_lst[r_wr] <= i_last;
`endif
        r_wr <= ptr_inc(r_wr);
      end
      if (i_pop) r_rd <= ptr_inc(r_rd);
      // Push and pop together leave occupancy unchanged.
      case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_occ  = r_occ;
  assign o_data = r_mem[r_rd];
`ifdef FIFO_RD_LAST_EN
  assign o_last = r_lst[r_rd];
`endif
endmodule

// File: rtl/fifo_rd_sched.sv
// Drains len words from a 1-cycle-latency FIFO read port into a valid/ready stream.
// Optional m_last output is enabled by defining FIFO_RD_LAST_EN.
module fifo_rd_sched
  import fifo_rd_pkg::*;
#(
  parameter int DW        = fifo_rd_pkg::DW,
  parameter int LENW      = fifo_rd_pkg::LENW,
  parameter int BUF_DEPTH = fifo_rd_pkg::BUF_DEPTH
) (
  input  logic            clkr,
  input  logic            rst,
  input  logic            start,
  input  logic [LENW-1:0] len,
  output logic            busy,
  output logic            done,
  output logic            fifo_re,
  input  logic [DW-1:0]   fifo_do,
  input  logic            fifo_empty,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [DW-1:0]   m_data
`ifdef FIFO_RD_LAST_EN
  , output logic          m_last
`endif
);
  state_e          r_state, w_state_nxt;
  logic [LENW-1:0] r_issue_cnt, r_out_cnt;
  logic            r_inflight, r_done;
  logic            w_re, w_pop, w_done_nxt, w_room, w_load;
  logic [1:0]      w_occ;
  logic [2:0]      w_pend;

  // Room check uses only registered occupancy so m_ready never reaches fifo_re.
  assign w_pend = {1'b0, w_occ} + {2'b0, r_inflight};
  assign w_room = (w_pend < 3'(BUF_DEPTH));
  assign w_pop  = m_valid && m_ready;
  assign w_load = (r_state == IDLE) && start && (len != '0);

  always_comb begin
    w_state_nxt = r_state;
    w_re        = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_load) w_state_nxt = RUN;
        if (start && (len == '0)) w_done_nxt = 1'b1;
      end
      RUN: begin
        w_re = !fifo_empty && (r_issue_cnt != '0) && w_room;
        if (w_re && (r_issue_cnt == LENW'(1))) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_pop && (r_out_cnt == LENW'(1))) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clkr) begin
    if (rst) begin
      r_state     <= IDLE;
      r_issue_cnt <= '0;
      r_out_cnt   <= '0;
      r_inflight  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_done     <= w_done_nxt;
      r_inflight <= w_re;
      if (w_load) begin
        r_issue_cnt <= len;
        r_out_cnt   <= len;
      end else begin
        if (w_re && (r_issue_cnt != '0))  r_issue_cnt <= r_issue_cnt - LENW'(1);
        if (w_pop && (r_out_cnt != '0))   r_out_cnt   <= r_out_cnt - LENW'(1);
      end
    end
  end

`ifdef FIFO_RD_LAST_EN
  logic r_inflight_last;
  always_ff @(posedge clkr) begin
    if (rst) r_inflight_last <= 1'b0;
    else     r_inflight_last <= w_re && (r_issue_cnt == LENW'(1));
  end
`endif

  fifo_rd_buf #(.DW(DW)) u_buf (
    .clk    (clkr),
    .rst    (rst),
    .i_push (r_inflight),
    .i_pop  (w_pop),
    .i_data (fifo_do),
`ifdef FIFO_RD_LAST_EN
    .i_last (r_inflight_last),
    .o_last (m_last),
`endif
    .o_occ  (w_occ),
    .o_data (m_data)
  );

  assign m_valid = (w_occ != 2'd0);
  assign busy    = (r_state != IDLE);
  assign done    = r_done;
  assign fifo_re = w_re;
endmodule
